// File: rtl/mem_resp_ctrl.sv
// Memory-side responder for the hello/ack handshake: owns the word RAM,
// inserts programmable wait states and answers with a four-phase ack.
module mem_resp_ctrl #(
   parameter int WORDSIZE    = 16,
   parameter int ADDRSIZE    = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                hello_i,
   input  logic                we_i,
   input  logic [ADDRSIZE-1:0] addr_i,
   input  logic [WORDSIZE-1:0] data_i,
   output logic [WORDSIZE-1:0] data_o,
   output logic                ack_o,
   output logic                err_o,
   output logic                busy_o,
   input  logic                dbg_we_i,
   input  logic [ADDRSIZE-1:0] dbg_addr_i,
   input  logic [WORDSIZE-1:0] dbg_data_i
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDRSIZE:0] DEPTH_W = (ADDRSIZE+1)'(DEPTH);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_REL
   } state_t;

   state_t state_q, state_d;

   logic [3:0]          cnt_q, cnt_d;
   logic                ack_d, err_d, busy_d;
   logic [WORDSIZE-1:0] data_d;

   logic [ADDRSIZE-1:0] lat_addr, lat_addr_d;
   logic                lat_we, lat_we_d;
   logic [WORDSIZE-1:0] lat_data, lat_data_d;

   logic [WORDSIZE-1:0] ram [DEPTH];
   logic                ram_we;
   logic [AW-1:0]       ram_waddr;
   logic [WORDSIZE-1:0] ram_wdata;
   logic [WORDSIZE-1:0] rd_word;

   logic lat_in, dbg_in;

   assign lat_in  = {1'b0, lat_addr} < DEPTH_W;
   assign dbg_in  = {1'b0, dbg_addr_i} < DEPTH_W;
   assign rd_word = ram[lat_addr[AW-1:0]];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ack_d      = ack_o;
      err_d      = err_o;
      data_d     = data_o;
      lat_addr_d = lat_addr;
      lat_we_d   = lat_we;
      lat_data_d = lat_data;
      ram_we     = 1'b0;
      ram_waddr  = lat_addr[AW-1:0];
      ram_wdata  = lat_data;
      unique case (state_q)
         ST_IDLE: begin
            // debug write lands first so a same-edge request sees it
            if (dbg_we_i && dbg_in) begin
               ram_we    = 1'b1;
               ram_waddr = dbg_addr_i[AW-1:0];
               ram_wdata = dbg_data_i;
            end
            if (hello_i) begin
               lat_addr_d = addr_i;
               lat_we_d   = we_i;
               lat_data_d = data_i;
               cnt_d      = WAIT_LD;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               err_d   = !lat_in;
               if (lat_we) begin
                  ram_we = lat_in;
               end else begin
                  data_d = lat_in ? rd_word : '0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACK: begin
            if (!hello_i) begin
               ack_d   = 1'b0;
               err_d   = 1'b0;
               state_d = ST_REL;
            end
         end
         ST_REL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ack_o    <= 1'b0;
         err_o    <= 1'b0;
         busy_o   <= 1'b0;
         data_o   <= '0;
         lat_addr <= '0;
         lat_we   <= 1'b0;
         lat_data <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ack_o    <= ack_d;
         err_o    <= err_d;
         busy_o   <= busy_d;
         data_o   <= data_d;
         lat_addr <= lat_addr_d;
         lat_we   <= lat_we_d;
         lat_data <= lat_data_d;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_waddr] <= ram_wdata;
      end
   end

endmodule

// File: doc/mem_resp_ctrl.md
Name: mem_resp_ctrl

Overview:
- Memory-side responder for the CPU's hello/ack memory handshake.
- The CPU side drives the request signals: hello, we, addr and write data.
- This block owns the word-addressed RAM, inserts a programmable number of wait states, and answers each request with a four-phase ack.
- It also provides a debug write port for loading program images while the CPU is held in reset.

Parameters:
- WORDSIZE, 16, data word width.
- ADDRSIZE, 8, address width.
- DEPTH, 256, number of implemented RAM words (DEPTH <= 2^ADDRSIZE).
- WAIT_CYCLES, 2, wait states inserted before ack (0..15).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- hello_i  input  1  request from CPU; held high until ack seen.
- we_i  input  1  1 = write, 0 = read; valid while hello_i high.
- addr_i  input  ADDRSIZE  word address; valid while hello_i high.
- data_i  input  WORDSIZE  write data from CPU.
- data_o  output  WORDSIZE  read data to CPU.
- ack_o  output  1  transaction complete; four-phase.
- err_o  output  1  high with ack_o when addr >= DEPTH.
- busy_o  output  1  high in any state other than IDLE.
- dbg_we_i  input  1  debug write strobe.
- dbg_addr_i  input  ADDRSIZE  debug write address.
- dbg_data_i  input  WORDSIZE  debug write data.

Behaviour:
- Reset (async, rst = 1):
  - State goes to IDLE.
  - ack_o = 0, err_o = 0, busy_o = 0, data_o = 0, wait counter = 0.
  - RAM contents are not cleared.
- States: IDLE, WAIT, ACK, REL. All outputs are registered.
- IDLE:
  - At an edge with hello_i = 1, latch addr_i, we_i and data_i.
  - Load counter = WAIT_CYCLES and go to WAIT.
  - busy_o rises on the same edge.
  - Later changes on addr_i, we_i or data_i do not affect the transaction.
- WAIT:
  - Each edge decrements the counter.
  - At the edge where counter == 0, commit the access, set ack_o = 1 and go to ACK.
  - Latency: ack_o rises WAIT_CYCLES + 1 edges after the accept edge.
  - With WAIT_CYCLES = 0, ack_o rises on the edge immediately after accept.
- Commit (same edge as the ack_o rise):
  - Read, in range: data_o <= ram[addr].
  - Write, in range: ram[addr] <= latched data; data_o is unchanged.
  - addr >= DEPTH: read loads data_o = 0, write is dropped, err_o = 1.
- ACK:
  - Hold ack_o (and err_o) while hello_i = 1.
  - At the first edge with hello_i = 0, clear ack_o and err_o and go to REL.
- REL:
  - One cycle; go to IDLE.
  - hello_i is ignored here, guaranteeing ack low for at least one cycle between transactions.
- data_o hold rule: data_o holds its value until the next read commit (including across writes and debug writes).
- Debug port:
  - dbg_we_i writes ram[dbg_addr_i] <= dbg_data_i only in IDLE.
  - If dbg_we_i and hello_i are both high in IDLE on the same edge, the debug write happens on that edge and the hello request is still accepted. The request reads the new value if the addresses match.
  - dbg_we_i in any other state is ignored.
  - An out-of-range dbg_addr_i is ignored.
- hello_i dropping during WAIT is a protocol violation. The transaction still completes; ACK then sees hello_i low and releases on the next edge.
- Reset during WAIT: the transaction is aborted and no write is committed. Reset during ACK or REL: ack_o drops immediately (async).
- RAM is inferred as a synchronous-write array. Reads are registered into data_o; there is no combinational read path to data_o.

Test Plan:
- Read latency:
  - Setup: WAIT_CYCLES = 2, dbg write ram[5] = 16'hBEEF, then hello = 1, we = 0, addr = 5 accepted at edge N.
  - Required: ack_o rises at edge N+3 with data_o = 16'hBEEF, busy_o high from N.
  - Then drop hello at N+4: ack_o low at N+5, IDLE at N+6.
- Write then read:
  - Stimulus: write 16'h1234 to addr 7, complete the handshake, then read addr 7.
  - Required: data_o = 16'h1234. data_o after the write ack still equals the previous read value.
- Zero wait states:
  - Setup: WAIT_CYCLES = 0, back-to-back reads of addr 1 and 2 (values 16'h0011, 16'h0022) with hello held until ack.
  - Required: each ack rises one edge after accept; the second request is not accepted before REL completes.
- Out of range:
  - Setup: DEPTH = 128.
  - Read addr 200: ack_o = 1, err_o = 1, data_o = 0.
  - Write 16'hFFFF to addr 200, then read addr 72: ram[72] is unchanged.
- Address stability:
  - Stimulus: change addr_i from 3 to 9 during WAIT.
  - Required: data_o = ram[3].
- Reset mid-write:
  - Stimulus: assert rst one cycle after accepting a write of 16'hAAAA to addr 4 (old value 16'h5555).
  - Required: ack_o, busy_o and data_o are 0 immediately; a later read of addr 4 returns 16'h5555.
